// File: rtl/spi_master_ctrl_if.sv
// Command/response bundle between a command source and spi_master_ctrl.
// master drives commands; slave (the controller) returns ready, status and read bytes.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  rd_data,
        input  rd_valid,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output rd_data,
        output rd_valid,
        output busy
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Parallel-to-SPI command master: serialises {op, data} frames onto SS_n/MOSI and,
// for read-data commands, deserialises the reply byte from MISO after a turnaround gap.
module spi_master_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_ctrl_if.slave bus,
    output logic             SS_n,
    output logic             MOSI,
    input  logic             MISO
);
    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(FW + 16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_TURN,
        S_CAPTURE,
        S_END
    } state_t;

    state_t                state_reg;
    logic [FW-1:0]         frame_reg;
    logic                  is_rd_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-2:0] shift_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  cmd_ready_reg;
    logic                  busy_reg;
    logic                  ss_n_reg;
    logic                  mosi_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            frame_reg     <= '0;
            is_rd_reg     <= 1'b0;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            ss_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        frame_reg     <= {bus.cmd_op, bus.cmd_data};
                        is_rd_reg     <= &bus.cmd_op;
                        ss_n_reg      <= 1'b0;
                        mosi_reg      <= bus.cmd_op[1];
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_START;
                    end
                end
                S_START: begin
                    // Frame is shifted left so its MSB is always the next bit on the wire.
                    mosi_reg  <= frame_reg[FW-1];
                    frame_reg <= {frame_reg[FW-2:0], 1'b0};
                    cnt_reg   <= CW'(FW - 1);
                    state_reg <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        mosi_reg  <= frame_reg[FW-1];
                        frame_reg <= {frame_reg[FW-2:0], 1'b0};
                    end else begin
                        mosi_reg <= 1'b0;
                        if (!is_rd_reg) begin
                            ss_n_reg  <= 1'b1;
                            state_reg <= S_END;
                        end else if (TURN_CYCLES > 0) begin
                            cnt_reg   <= CW'(TURN_CYCLES - 1);
                            state_reg <= S_TURN;
                        end else begin
                            cnt_reg   <= CW'(DATA_WIDTH - 1);
                            state_reg <= S_CAPTURE;
                        end
                    end
                end
                S_TURN: begin
                    if (cnt_reg == '0) begin
                        cnt_reg   <= CW'(DATA_WIDTH - 1);
                        state_reg <= S_CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    shift_reg <= {shift_reg[DATA_WIDTH-3:0], MISO};
                    if (cnt_reg == '0) begin
                        // Last bit goes straight into rd_data so it is valid in the END cycle.
                        rd_data_reg  <= {shift_reg, MISO};
                        rd_valid_reg <= 1'b1;
                        ss_n_reg     <= 1'b1;
                        state_reg    <= S_END;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_END: begin
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    ss_n_reg      <= 1'b1;
                    mosi_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign SS_n          = ss_n_reg;
    assign MOSI          = mosi_reg;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: instance 0 uses TURN_CYCLES=2, instance 1 uses 0.
// The driver pushes hand-computed frame expectations; a per-instance SS_n monitor pops and checks them.
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       valid_a [2];
    logic [1:0] op_a    [2];
    logic [7:0] data_a  [2];
    logic       ready_a [2];
    logic       busy_a  [2];
    logic       rdv_a   [2];
    logic [7:0] rdd_a   [2];
    logic       ss_a    [2];
    logic       mosi_a  [2];
    logic       miso_a  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        spi_master_ctrl_if #(.DATA_WIDTH(8)) bus ();
        assign bus.cmd_valid = valid_a[gi];
        assign bus.cmd_op    = op_a[gi];
        assign bus.cmd_data  = data_a[gi];
        assign ready_a[gi]   = bus.cmd_ready;
        assign busy_a[gi]    = bus.busy;
        assign rdv_a[gi]     = bus.rd_valid;
        assign rdd_a[gi]     = bus.rd_data;

        spi_master_ctrl #(
            .DATA_WIDTH (8),
            .TURN_CYCLES((gi == 0) ? 2 : 0)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave),
            .SS_n (ss_a[gi]),
            .MOSI (mosi_a[gi]),
            .MISO (miso_a[gi])
        );
    end

    typedef struct {
        int          dut;
        logic [10:0] mosi;
        int          len;
        bit          rdv;
        logic [7:0]  rdd;
        int          accept;
        bit          b2b;
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   turn_of  [2] = '{2, 0};

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Slave-side MISO model: drives one byte MSB first starting at a given cycle.
    int         miso_start [2] = '{-1000, -1000};
    logic [7:0] miso_byte  [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int k;
            k = cyc - miso_start[d];
            if (k >= 0 && k < 8) miso_a[d] = miso_byte[d][7-k];
            else                 miso_a[d] = 1'b0;
        end
    end

    // Frame monitor
    exp_t        cur       [2];
    bit          have      [2];
    bit          in_frame  [2];
    bit          chk_next  [2];
    int          low_cnt   [2];
    int          extra     [2];
    int          bad_hs    [2];
    int          last_rise [2] = '{-100, -100};
    int          stray     [2] = '{0, 0};
    logic [10:0] bits      [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_next[d]) begin
                chk(ready_a[d] && !busy_a[d], "ready_after_end", {ready_a[d], busy_a[d]}, 2);
                chk_next[d] = 1'b0;
            end
            if (!ss_a[d] && !in_frame[d]) begin
                in_frame[d] = 1'b1;
                low_cnt[d]  = 0;
                extra[d]    = 0;
                bad_hs[d]   = 0;
                bits[d]     = '0;
                if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                    have[d] = 1'b0;
                    chk(1'b0, "unexpected_frame", d, -1);
                end else begin
                    have[d] = 1'b1;
                    cur[d]  = exp_q.pop_front();
                    chk(cyc - cur[d].accept == 1, "start_cycle", cyc - cur[d].accept, 1);
                    if (cur[d].b2b)
                        chk(cyc - last_rise[d] == 2, "ss_high_gap", cyc - last_rise[d], 2);
                end
            end
            if (!ss_a[d]) begin
                low_cnt[d]++;
                if (low_cnt[d] <= 11) bits[d] = {bits[d][9:0], mosi_a[d]};
                else if (mosi_a[d])   extra[d]++;
                if (ready_a[d] || !busy_a[d] || rdv_a[d]) bad_hs[d]++;
            end else if (in_frame[d]) begin
                in_frame[d]  = 1'b0;
                last_rise[d] = cyc;
                if (have[d]) begin
                    chk(low_cnt[d] == cur[d].len, "ss_low_len", low_cnt[d], cur[d].len);
                    chk(bits[d] == cur[d].mosi, "mosi_bits", int'(bits[d]), int'(cur[d].mosi));
                    chk(extra[d] == 0, "mosi_zero_after_shift", extra[d], 0);
                    chk(bad_hs[d] == 0, "ready_busy_in_frame", bad_hs[d], 0);
                    chk(rdv_a[d] == cur[d].rdv, "rd_valid_end", int'(rdv_a[d]), int'(cur[d].rdv));
                    chk(rdd_a[d] == cur[d].rdd, "rd_data_end", int'(rdd_a[d]), int'(cur[d].rdd));
                    if (!cur[d].abort) begin
                        chk(!ready_a[d] && busy_a[d], "end_busy", {ready_a[d], busy_a[d]}, 1);
                        chk_next[d] = 1'b1;
                    end
                end
            end else if (rdv_a[d]) begin
                stray[d]++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] miso, input logic [10:0] mosi_exp,
                        input int len, input bit rdv, input logic [7:0] rdd,
                        input bit hold, input bit b2b, input bit abort, output int acc);
        exp_t e;
        int   n;
        op_a[d]    = op;
        data_a[d]  = data;
        valid_a[d] = 1'b1;
        n = 0;
        while (!ready_a[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!ready_a[d]) begin
            chk(1'b0, "accept_timeout", n, 100);
            valid_a[d] = 1'b0;
            return;
        end
        e.dut = d; e.mosi = mosi_exp; e.len = len; e.rdv = rdv; e.rdd = rdd;
        e.accept = acc; e.b2b = b2b; e.abort = abort;
        exp_q.push_back(e);
        if (op == 2'b11) begin
            miso_byte[d]  = miso;
            miso_start[d] = acc + 12 + turn_of[d];
        end
        @(negedge clk);
        if (!hold) begin
            valid_a[d] = 1'b0;
            data_a[d]  = ~data;
            op_a[d]    = ~op;
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!(ready_a[d] && ss_a[d]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(1'b0, "idle_timeout", n, 100);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int acc;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid_a[d] = 1'b0;
            op_a[d]    = 2'b00;
            data_a[d]  = 8'h00;
            miso_byte[d] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(ss_a[d] && !mosi_a[d], "reset_ss_mosi", {ss_a[d], mosi_a[d]}, 2);
            chk(ready_a[d] && !busy_a[d], "reset_ready_busy", {ready_a[d], busy_a[d]}, 2);
            chk(!rdv_a[d] && rdd_a[d] == 8'h00, "reset_rd", {rdv_a[d], rdd_a[d]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        send(0, 2'b00, 8'h3C, 8'h00, 11'b00000111100, 11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(0);
        send(0, 2'b11, 8'h00, 8'hA5, 11'b11100000000, 21, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(0);

        send(0, 2'b01, 8'hFF, 8'h00, 11'b00111111111, 11, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, acc);
        send(0, 2'b10, 8'h00, 8'h00, 11'b11000000000, 11, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
        wait_idle(0);

        // Abort a read-data frame with reset during cycle 15.
        send(0, 2'b11, 8'h5C, 8'h00, 11'b11101011100, 14, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        while (cyc < acc + 14) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(ss_a[0] == 1'b1, "async_reset_ss", int'(ss_a[0]), 1);
        chk(busy_a[0] == 1'b0, "async_reset_busy", int'(busy_a[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(0, 2'b11, 8'hFF, 8'h69, 11'b11111111111, 21, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(0);
        send(0, 2'b00, 8'h81, 8'h00, 11'b00010000001, 11, 1'b0, 8'h69, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(0);

        send(1, 2'b11, 8'h00, 8'h5A, 11'b11100000000, 19, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(1);
        send(1, 2'b00, 8'hA5, 8'h00, 11'b00010100101, 11, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
        wait_idle(1);

        chk(exp_q.size() == 0, "frames_outstanding", exp_q.size(), 0);
        for (int d = 0; d < 2; d++)
            chk(stray[d] == 0, "stray_rd_valid", stray[d], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Parallel-to-SPI command master that drives the SPI wrapper (SPI slave + RAM) on the same clock.
- Accepts one command per transaction (2-bit opcode + data byte) through a valid/ready handshake.
- Serialises the command onto SS_n/MOSI.
- For read-data commands, deserialises the 8-bit reply returned on MISO.
- Sits directly upstream of the wrapper; it is the stimulus source that the wrapper's MISO/SS_n assertions observe.

Parameters:
- DATA_WIDTH, 8: payload bits per frame. The serial frame is DATA_WIDTH+2 bits.
- TURN_CYCLES, 2: idle cycles (SS_n low, MOSI=0) between the last MOSI bit and the first MISO sample of a read-data frame. Legal range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; handshake completes when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
- cmd_data  in  DATA_WIDTH  address or write byte; ignored (sent as-is) for 11
- rd_data  out  DATA_WIDTH  byte captured from MISO; holds until the next rd-data completion
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- busy  out  1  high in every state except IDLE
- SS_n  out  1  slave select, active low
- MOSI  out  1  serial data to slave, MSB first
- MISO  in  1  serial data from slave, sampled on rising edge

Behaviour:
- Reset (async, any state): state=IDLE, SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=0, counters=0.
  - Reset mid-frame aborts the frame immediately; no rd_valid is produced for the aborted frame.
- All serial outputs are registered. "Cycle n" means the n-th clock cycle after the accepting edge.
- States: IDLE -> START -> SHIFT -> (TURN -> CAPTURE) -> END -> IDLE.
- IDLE: SS_n=1, MOSI=0, cmd_ready=1.
  - On handshake, latch frame={cmd_op,cmd_data} and go to START.
  - cmd_valid held while busy is ignored; it is accepted only when cmd_ready=1.
- START (cycle 1): SS_n=0, MOSI=cmd_op[1] (slave's write/read selector bit).
- SHIFT (cycles 2..DATA_WIDTH+3): SS_n=0, MOSI=frame[DATA_WIDTH+1] down to frame[0], one bit per cycle, via a down-counter.
- After SHIFT, opcode 11 goes to TURN; all other opcodes go to END.
- TURN: TURN_CYCLES cycles, SS_n=0, MOSI=0. If TURN_CYCLES=0, go straight to CAPTURE.
- CAPTURE: DATA_WIDTH cycles, SS_n=0, MOSI=0.
  - MISO is shifted in MSB first at the rising edge ending each CAPTURE cycle.
- END: one cycle with SS_n=1, MOSI=0, busy=1.
  - For opcode 11: rd_data is loaded and rd_valid=1 in this cycle only.
  - Next cycle: IDLE.
- Frame lengths with defaults:
  - Write or rd-addr: SS_n low for 11 cycles (1..11); END at 12; cmd_ready back at 13.
  - Rd-data: SS_n low for cycles 1..21 (11 shift + 2 turn + 8 capture); END/rd_valid at 22.
- Inter-frame gap: SS_n stays high for at least 2 cycles (END + IDLE accept cycle).
  - Back-to-back accepts produce SS_n high for exactly 2 cycles.
- No error signalling; opcode sequencing legality (e.g. rd-data before rd-addr) is the slave's concern.

Test Plan:
- Reset then cmd_op=00, cmd_data=0x3C -> MOSI over cycles 1..11 = 0,0,0,0,0,1,1,1,1,0,0; SS_n low cycles 1..11, high cycle 12; cmd_ready=1 cycle 13; rd_valid never asserted.
- cmd_op=11, slave drives MISO=1,0,1,0,0,1,0,1 during CAPTURE -> rd_data=0xA5 with rd_valid=1 exactly at cycle 22; SS_n low cycles 1..21.
- Back-to-back 01/0xFF then 10/0x00 with cmd_valid held high -> second accept at cycle 13; SS_n high for exactly cycles 12..13; cmd_ready low throughout each frame.
- rst_n asserted at cycle 15 of an 11 frame -> SS_n=1 and busy=0 asynchronously; rd_valid stays 0; the next command frames correctly.
- TURN_CYCLES=0 rebuild with MISO=0x5A -> first sample at the end of cycle 12; rd_valid at cycle 20 with rd_data=0x5A.
- cmd_data changes while busy -> transmitted bits match the value latched at accept.
